// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM state type and lane constants shared across the MIPS_32 datapath
// Contents: opcode localparams (R/I/branch/jump and memory ops), state_t, BYTE_W,
// helpers to classify memory opcodes and check address alignment.
package mips_pkg;
    localparam int BYTE_W = 8;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    function automatic logic is_mem_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction
    // op[1:0] encodes access size for every memory op: 00 byte, 01 half, 11 word
    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] off);
        return op[1] ? off == 2'b00 : op[0] ? !off[0] : 1'b1;
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-wide data memory req/ack bus
// Signals: mem_req/mem_we/mem_be/mem_addr/mem_wdata (unit -> memory),
// mem_rdata/mem_ack (memory -> unit). master = access unit, slave = memory.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    modport master(output mem_req, mem_we, mem_be, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave(input mem_req, mem_we, mem_be, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_access_unit_load_extract.sv
// load_extract: selects the addressed byte/half of a big-endian word and extends it
// Ports: mem_rdata_i (read word), offset_i (addr[1:0]), opcode_i (load opcode),
// ext_o (sign/zero-extended result; full word for lw and non-sub-word opcodes).
module load_extract
    import mips_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [5:0]  opcode_i,
    output logic [31:0] ext_o
);
    logic [BYTE_W-1:0]   b;
    logic [2*BYTE_W-1:0] h;
    assign b = offset_i == 2'd0 ? mem_rdata_i[31:24] :
               offset_i == 2'd1 ? mem_rdata_i[23:16] :
               offset_i == 2'd2 ? mem_rdata_i[15:8]  : mem_rdata_i[7:0];
    assign h = offset_i[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
    assign ext_o = opcode_i == OP_LB  ? {{24{b[7]}}, b} :
                   opcode_i == OP_LBU ? {24'h0, b} :
                   opcode_i == OP_LH  ? {{16{h[15]}}, h} :
                   opcode_i == OP_LHU ? {16'h0, h} : mem_rdata_i;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS_32 data-memory stage running a req/ack access per load/store
// Ports: clk, rst_n (async active-low); valid_in/opcode/addr/rt_reg from the ALU stage;
// stall back to upstream; load_data with pulses load_valid/store_done/misalign/bus_error;
// mem (master side of mem_access_unit_if) to the word-wide data memory.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] rt_reg,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        store_done,
    output logic        misalign,
    output logic        bus_error,
    mem_access_unit_if.master mem
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic        req_q, we_q, lv_q, sd_q, mis_q, err_q;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, wdata_q, wdata_d, ld_q, ext;
    logic        mem_op, aligned, accept, timeout, done;
    assign mem_op  = is_mem_op(opcode);
    assign aligned = is_aligned(opcode, addr[1:0]);
    // gated with rst_n so stall falls the moment reset asserts
    assign accept  = rst_n && state_q == IDLE && valid_in && mem_op && aligned;
    assign timeout = ACK_TIMEOUT != 0 && cnt_q == CNT_W'(ACK_TIMEOUT - 1);
    assign done    = state_q == ACCESS && (mem.mem_ack || timeout);
    assign stall   = accept || state_q == ACCESS;
    assign be_d    = opcode[1] ? 4'b1111 : opcode[0] ? (addr[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> addr[1:0];
    assign wdata_d = opcode[1] ? rt_reg : opcode[0] ? {2{rt_reg[15:0]}} : {4{rt_reg[7:0]}};
    load_extract u_extract (.mem_rdata_i(mem.mem_rdata), .offset_i(off_q), .opcode_i(op_q), .ext_o(ext));
    always_comb begin
        state_d = accept ? ACCESS : done ? RESP : state_q == RESP ? IDLE : state_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= '0;
            off_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            lv_q    <= 1'b0;
            sd_q    <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            req_q <= state_d == ACCESS;
            lv_q  <= done && mem.mem_ack && !op_q[3];
            sd_q  <= done && mem.mem_ack && op_q[3];
            err_q <= done && !mem.mem_ack;
            mis_q <= state_q == IDLE && valid_in && mem_op && !aligned;
            cnt_q <= accept ? '0 : state_q == ACCESS ? cnt_q + CNT_W'(1) : cnt_q;
            if (accept) begin
                op_q    <= opcode;
                off_q   <= addr[1:0];
                addr_q  <= {addr[31:2], 2'b00};
                be_q    <= be_d;
                wdata_q <= wdata_d;
                we_q    <= opcode[3];
            end
            if (state_q == ACCESS && mem.mem_ack && !op_q[3]) ld_q <= ext;
        end
    end
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign load_data     = ld_q;
    assign load_valid    = lv_q;
    assign store_done    = sd_q;
    assign misalign      = mis_q;
    assign bus_error     = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with a per-cycle transaction model of the access unit
module tb_mem_access_unit;
    import mips_pkg::*;
    localparam int TMO = 16;
    logic clk = 1'b0;
    logic rst_n, valid_in;
    logic [5:0]  opcode;
    logic [31:0] addr, rt_reg, load_data;
    logic stall, load_valid, store_done, misalign, bus_error;
    logic        e_stall, e_req, e_we, e_lv, e_sd, e_mis, e_err;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_ld;
    int n_chk = 0;
    int n_fail = 0;
    mem_access_unit_if mif();
    mem_access_unit #(.ACK_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .addr(addr),
        .rt_reg(rt_reg), .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .store_done(store_done), .misalign(misalign), .bus_error(bus_error), .mem(mif.master)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask
    function automatic int op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction
    function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
        logic [3:0] be = '0;
        int first = int'(a % 4);
        for (int j = 0; j < 4; j++)
            if (j >= first && j < first + op_size(op)) be[3-j] = 1'b1;
        return be;
    endfunction
    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] rt);
        logic [31:0] w = '0;
        int sz = op_size(op);
        for (int j = 0; j < 4; j++) w[31-8*j -: 8] = rt[8*((sz-1) - (j % sz)) +: 8];
        return w;
    endfunction
    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
        int sz = op_size(op);
        logic [31:0] v = rd >> (8 * (4 - int'(a % 4) - sz));
        logic [31:0] mask = sz == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 1;
        v = v & mask;
        if ((op == OP_LB || op == OP_LH) && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~mask;
        return v;
    endfunction
    always @(negedge clk) begin
        chk("stall", stall, e_stall);
        chk("mem_req", mif.mem_req, e_req);
        chk("load_valid", load_valid, e_lv);
        chk("store_done", store_done, e_sd);
        chk("misalign", misalign, e_mis);
        chk("bus_error", bus_error, e_err);
        chk("load_data", load_data, e_ld);
        if (e_req) begin
            chk("mem_addr", mif.mem_addr, e_addr);
            chk("mem_be", mif.mem_be, e_be);
            chk("mem_we", mif.mem_we, e_we);
            chk("mem_wdata", mif.mem_wdata, e_wdata);
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clr_exp();
        {e_stall, e_req, e_lv, e_sd, e_mis, e_err} = '0;
    endtask
    task automatic run_mem(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                           input logic [31:0] rd, input int ack_at);
        logic st = op == OP_SB || op == OP_SH || op == OP_SW;
        tick();
        valid_in = 1'b1; opcode = op; addr = a; rt_reg = rt; mif.mem_ack = 1'b0;
        clr_exp(); e_stall = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick();
            e_stall = 1'b1; e_req = 1'b1; e_we = st;
            e_addr = a & ~32'h3; e_be = m_be(op, a); e_wdata = m_wdata(op, rt);
            mif.mem_ack = k == ack_at;
            mif.mem_rdata = k == ack_at ? rd : $urandom;
            if (k == ack_at || (ack_at < 0 && k == TMO - 1)) break;
        end
        tick();
        mif.mem_ack = 1'b1;
        mif.mem_rdata = $urandom;
        clr_exp();
        if (ack_at < 0) e_err = 1'b1;
        else if (st) e_sd = 1'b1;
        else begin
            e_lv = 1'b1;
            e_ld = m_load(op, a, rd);
        end
        tick();
        valid_in = 1'b0; mif.mem_ack = 1'b0;
        clr_exp();
    endtask
    task automatic run_nomem(input logic [5:0] op, input logic [31:0] a, input logic mis);
        tick();
        valid_in = 1'b1; opcode = op; addr = a; rt_reg = $urandom;
        clr_exp();
        tick();
        valid_in = 1'b0;
        e_mis = mis;
        tick();
        clr_exp();
    endtask
    initial begin
        rst_n = 1'b1; valid_in = 1'b0; opcode = '0; addr = '0; rt_reg = '0;
        mif.mem_rdata = '0; mif.mem_ack = 1'b0;
        clr_exp(); e_ld = '0; e_we = 1'b0; e_be = '0; e_addr = '0; e_wdata = '0;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_mem(OP_LW, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 1);
        chk("lw_lit_data", load_data, 32'hDEAD_BEEF);
        chk("lw_lit_addr", mif.mem_addr, 32'h0000_0104);
        chk("lw_lit_be", mif.mem_be, 32'hF);
        run_mem(OP_LB, 32'h0000_0101, 32'h0, 32'h1280_3456, 0);
        chk("lb_lit", load_data, 32'hFFFF_FF80);
        run_mem(OP_LBU, 32'h0000_0101, 32'h0, 32'h1280_3456, 0);
        chk("lbu_lit", load_data, 32'h0000_0080);
        run_mem(OP_LH, 32'h0000_0102, 32'h0, 32'h0000_9ABC, 2);
        chk("lh_lit", load_data, 32'hFFFF_9ABC);
        run_mem(OP_SB, 32'h0000_0203, 32'h1122_3344, 32'h0, 0);
        chk("sb_lit_be", mif.mem_be, 32'h1);
        chk("sb_lit_wdata", mif.mem_wdata, 32'h4444_4444);
        run_mem(OP_SH, 32'h0000_0202, 32'h1122_3344, 32'h0, 0);
        chk("sh_lit_be", mif.mem_be, 32'h3);
        chk("sh_lit_wdata", mif.mem_wdata, 32'h3344_3344);
        run_nomem(OP_SW, 32'h0000_0106, 1'b1);
        run_nomem(OP_LH, 32'h0000_0101, 1'b1);
        run_mem(OP_LW, 32'h0000_0200, 32'h0, 32'h0, -1);
        chk("tmo_lit_data", load_data, 32'hFFFF_9ABC);
        tick();
        valid_in = 1'b1; opcode = OP_LW; addr = 32'h0000_0300;
        clr_exp(); e_stall = 1'b1;
        tick();
        e_req = 1'b1; e_we = 1'b0; e_addr = 32'h0000_0300; e_be = 4'hF; e_wdata = m_wdata(OP_LW, rt_reg);
        tick();
        rst_n = 1'b0;
        clr_exp(); e_ld = '0;
        tick();
        valid_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_mem(OP_SW, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0);
        chk("sw_lit_wdata", mif.mem_wdata, 32'hCAFE_F00D);
        chk("sw_lit_addr", mif.mem_addr, 32'h0000_0010);
        run_nomem(OP_ADDI, 32'h0000_0010, 1'b0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory stage directly downstream of the ALU in the MIPS_32 datapath.
- Takes the ALU result as the effective address for lb/lh/lw/lbu/lhu/sb/sh/sw and the rt register as store data.
- Runs a req/ack handshake to a word-wide data memory, stalling upstream until the access completes.
- Returns lane-extracted, sign- or zero-extended load data.

Parameters:
- ACK_TIMEOUT, 16: cycles in ACCESS without mem_ack before abort; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must satisfy 2**CNT_W > ACK_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  opcode/addr/rt_reg valid this cycle.
- opcode  input  6  instruction opcode.
- addr  input  32  effective address (ALU writeData).
- rt_reg  input  32  store data.
- stall  output  1  upstream must hold inputs while high.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write.
- mem_be  output  4  byte enables; bit 3 = byte at addr[1:0]=0.
- mem_addr  output  32  word address: {addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated store data.
- mem_rdata  input  32  read data, valid with mem_ack.
- mem_ack  input  1  access complete.
- load_data  output  32  extended load result.
- load_valid  output  1  one-cycle pulse, load_data updated.
- store_done  output  1  one-cycle pulse, store committed.
- misalign  output  1  one-cycle pulse, misaligned access rejected.
- bus_error  output  1  one-cycle pulse, ack timeout.

Behaviour:
- Opcodes:
  - lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101.
  - sb 101000, sh 101001, sw 101011.
  - Any other opcode is ignored; stall stays 0.
- Big-endian lanes; offset = addr[1:0].
  - Byte: be = 4'b1000 >> offset.
  - Half: be = 1100 if addr[1]=0, else 0011.
  - Word: be = 1111.
- Store data:
  - sb: wdata = {4{rt[7:0]}}.
  - sh: wdata = {2{rt[15:0]}}.
  - sw: wdata = rt.
- Loads:
  - Select the byte/half of mem_rdata addressed by offset.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
  - Misaligned op in IDLE: no memory access, misalign pulses the next cycle, stall=0 throughout, state stays IDLE.
- FSM states IDLE, ACCESS, RESP.
  - IDLE -> ACCESS when valid_in, memory opcode and aligned. Capture opcode, offset, mem_addr, mem_be, mem_wdata and mem_we into registers.
  - ACCESS: mem_req=1. All mem_* outputs come from registers and stay stable until ack.
  - ACCESS, mem_ack=1: capture the extended load_data for loads; go to RESP. mem_req drops the next cycle. Same-cycle ack is allowed (ACCESS lasts 1 cycle minimum).
  - ACCESS, timeout counter reaches ACK_TIMEOUT-1 with no ack: go to RESP with the error flag set. Data is not captured.
  - RESP: exactly one of load_valid/store_done/bus_error is 1. Go to IDLE. New requests are not accepted in RESP.
- Timeout counter: cleared on entry to ACCESS, increments each ACCESS cycle. With ACK_TIMEOUT=0 it never expires.
- stall = (IDLE & valid_in & mem-op & aligned) | ACCESS.
  - stall is 0 in RESP, so upstream advances at the end of RESP.
  - Latency: load/store with ack in the first ACCESS cycle = 3 cycles, accept to RESP pulse.
- load_data holds its last value until the next successful load.
- mem_ack outside ACCESS is ignored.
- Reset: asynchronous, forces IDLE.
  - Registered outputs reset to 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_data, load_valid, store_done, misalign, bus_error, counter.
  - mem_req drops immediately. An in-flight access is abandoned with no pulse.

Decomposition:
- Shared package mips_pkg holds:
  - the opcode localparams (mem ops plus the ALU's R/I/branch opcodes);
  - the state typedef {IDLE, ACCESS, RESP};
  - the byte-lane width constant.
- One sub-module, load_extract: combinational. Inputs mem_rdata, offset, opcode; output the 32-bit extended value. It is reused later for writeback forwarding.

Test Plan:
- lw, addr=0x0000_0104, mem_rdata=0xDEAD_BEEF, ack in 2nd ACCESS cycle -> mem_addr=0x104, be=1111, stall high 3 cycles, then load_data=0xDEADBEEF with a 1-cycle load_valid.
- lb/lbu, addr=0x0000_0101, rdata=0x1280_3456 -> lb gives 0xFFFF_FF80, lbu gives 0x0000_0080. Repeat lh at 0x102, rdata=0x0000_9ABC -> 0xFFFF_9ABC.
- sb, addr=0x0000_0203, rt=0x1122_3344 -> be=0001, mem_we=1, wdata=0x4444_4444, store_done pulse. sh at 0x202 -> be=0011, wdata=0x3344_3344.
- sw at 0x0000_0106 -> no mem_req, misalign pulses 1 cycle, stall stays 0. Same for lh at 0x...01.
- lw with mem_ack held 0, ACK_TIMEOUT=16 -> mem_req high exactly 16 cycles, then bus_error pulse, load_data unchanged, back to IDLE.
- rst_n low in the 2nd ACCESS cycle -> mem_req and stall drop immediately with no pulses. After release, an sw to 0x10 completes normally; addi opcode with valid_in -> stall 0, no mem_req.
